fetch_queue: RTL

Parametrised instruction fetch queue between the ICache stage and decode, replacing the fixed 4-deep, 4-wide buffer. It accepts a group of up to IN_W instructions per cycle with a sparse per-slot valid mask, compacts the valid slots in program order into a circular store, and presents up to OUT_W oldest entries to decode. Decode retires a variable count each cycle. Flush support covers branch redirect.

---
 rtl/frontend_pkg.sv | 23 ++
 rtl/fq_compact.sv | 25 ++
 rtl/fetch_queue.sv | 109 ++++++++++
 3 files changed

// File: rtl/frontend_pkg.sv
// rtl/frontend_pkg.sv - shared fetch-frontend constants, entry type and popcount helper
package frontend_pkg;

    localparam int INST_W   = 32;
    localparam int FQ_DEPTH = 16;
    localparam int FQ_IN_W  = 4;
    localparam int FQ_OUT_W = 4;

    typedef struct packed {
        logic [31:0]       pc;
        logic [INST_W-1:0] inst;
    } fq_entry_t;

    function automatic int unsigned popcount(input logic [31:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            n = n + {31'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/fq_compact.sv
// rtl/fq_compact.sv - per-slot destination offsets (prefix popcount) for sparse fetch groups
module fq_compact
    import frontend_pkg::*;
#(
    parameter int IN_W  = FQ_IN_W,
    parameter int OFF_W = $clog2(IN_W + 1)
) (
    input  logic [IN_W-1:0]       in_mask,
    output logic [IN_W*OFF_W-1:0] dest_off,
    output logic [OFF_W-1:0]      n_in
);

    // Slot i lands after every valid slot below it, keeping program order.
    always_comb begin
        logic [OFF_W-1:0] run;
        run = '0;
        for (int i = 0; i < IN_W; i++) begin
            dest_off[i*OFF_W +: OFF_W] = run;
            run = run + OFF_W'(in_mask[i]);
        end
    end

    assign n_in = OFF_W'(popcount(32'(in_mask)));

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - compacting instruction fetch queue; FETCH_QUEUE_STATS_EN adds stall/empty counters
module fetch_queue
    import frontend_pkg::*;
#(
    parameter int DEPTH = FQ_DEPTH,
    parameter int IN_W  = FQ_IN_W,
    parameter int OUT_W = FQ_OUT_W,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int ACC_W = $clog2(OUT_W + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [IN_W*INST_W-1:0]  in_inst,
    input  logic [31:0]             in_pc,
    input  logic [IN_W-1:0]         in_mask,
    output logic [OUT_W*INST_W-1:0] out_inst,
    output logic [OUT_W*32-1:0]     out_pc,
    output logic [OUT_W-1:0]        out_valid,
    input  logic [ACC_W-1:0]        out_accept,
    output logic [CNT_W-1:0]        count
`ifdef FETCH_QUEUE_STATS_EN
    ,
    output logic [31:0]             full_stall_cnt,
    output logic [31:0]             empty_cnt
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OFF_W = $clog2(IN_W + 1);

    fq_entry_t              mem [DEPTH];
    logic [PTR_W-1:0]       head;
    logic [PTR_W-1:0]       tail;
    logic [IN_W*OFF_W-1:0]  dest_off;
    logic [OFF_W-1:0]       n_in;
    logic [CNT_W-1:0]       avail;
    logic [CNT_W-1:0]       n_out;
    logic                   push;

    fq_compact #(.IN_W(IN_W), .OFF_W(OFF_W)) u_compact (
        .in_mask  (in_mask),
        .dest_off (dest_off),
        .n_in     (n_in)
    );

    // Whole groups only: ready needs room for IN_W regardless of the mask.
    assign in_ready = count <= CNT_W'(DEPTH - IN_W);
    assign push     = in_valid && in_ready && !flush;
    assign avail    = (count < CNT_W'(OUT_W)) ? count : CNT_W'(OUT_W);
    assign n_out    = (CNT_W'(out_accept) < avail) ? CNT_W'(out_accept) : avail;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                for (int i = 0; i < IN_W; i++) begin
                    if (in_mask[i]) begin
                        mem[tail + PTR_W'(dest_off[i*OFF_W +: OFF_W])] <=
                            '{pc: in_pc + 32'(4 * i), inst: in_inst[i*INST_W +: INST_W]};
                    end
                end
            end
            head  <= head + PTR_W'(n_out);
            tail  <= push ? tail + PTR_W'(n_in) : tail;
            count <= count + (push ? CNT_W'(n_in) : CNT_W'(0)) - n_out;
        end
    end

    always_comb begin
        fq_entry_t rd;
        rd = '0;
        for (int i = 0; i < OUT_W; i++) begin
            rd           = mem[head + PTR_W'(i)];
            out_valid[i] = count > CNT_W'(i);
            out_inst[i*INST_W +: INST_W] = out_valid[i] ? rd.inst : '0;
            out_pc[i*32 +: 32]           = out_valid[i] ? rd.pc : '0;
        end
    end

`ifdef FETCH_QUEUE_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_stall_cnt <= '0;
            empty_cnt      <= '0;
        end else begin
            if (in_valid && !in_ready) begin
                full_stall_cnt <= full_stall_cnt + 32'd1;
            end
            if (count == '0) begin
                empty_cnt <= empty_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
